// File: rtl/rr_burst_arbiter.sv
// Four-requester round-robin arbiter with per-burst grant locking and a beat counter.
// Optional stall-timeout release is built when RR_TIMEOUT_EN is defined.
module rr_burst_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_i,
    input  logic [3:0]       last_i,
    input  logic             ready_i,
    output logic [3:0]       grant_o,
    output logic             gnt_valid_o,
    output logic [1:0]       gnt_id_o,
    output logic [CNT_W-1:0] beat_cnt_o,
    output logic             timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       gnt_id_q;
    logic [3:0]       grant_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic       pick_found;
    logic [1:0] pick_id;
    logic [1:0] cand;
    logic       beat;
    logic       at_limit;
    logic       release_now;
    logic       tmo_fire;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first active request.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = ptr_q;
        cand       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign beat     = (state_q == StGrant) && req_i[gnt_id_q] && ready_i;
    assign at_limit = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    // Abort, last beat, burst limit, or stall timeout all end the burst the same way.
    assign release_now = (state_q == StGrant) &&
                         (!req_i[gnt_id_q] || (beat && (last_i[gnt_id_q] || at_limit)) ||
                          tmo_fire);

`ifdef RR_TIMEOUT_EN
    localparam int unsigned StallW = 16;

    logic [StallW-1:0] stall_q;
    logic              timeout_q;

    // Requires req held and ready low, so abort and a same-cycle beat both win over timeout.
    assign tmo_fire = (state_q == StGrant) && req_i[gnt_id_q] && !ready_i &&
                      (stall_q == StallW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_fire;
            if (state_q == StIdle || beat) begin
                stall_q <= '0;
            end else if (req_i[gnt_id_q] && !ready_i) begin
                stall_q <= stall_q + StallW'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign tmo_fire       = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 2'd0;
            gnt_id_q   <= 2'd0;
            grant_q    <= 4'b0000;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q    <= 4'b0001 << pick_id;
                        gnt_id_q   <= pick_id;
                        beat_cnt_q <= '0;
                        state_q    <= StGrant;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        grant_q    <= 4'b0000;
                        gnt_id_q   <= 2'd0;
                        beat_cnt_q <= '0;
                        ptr_q      <= gnt_id_q + 2'd1;
                        state_q    <= StIdle;
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign gnt_valid_o = |grant_q;
    assign gnt_id_o    = gnt_id_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: the driver queues expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_rr_burst_arbiter;

    localparam int unsigned MaxBurst = 8;
    localparam int unsigned CntW     = 8;
    localparam int unsigned Timeout  = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [3:0]      req   = 4'b0000;
    logic [3:0]      last  = 4'b0000;
    logic            ready = 1'b0;
    logic [3:0]      grant;
    logic            gnt_valid;
    logic [1:0]      gnt_id;
    logic [CntW-1:0] beat_cnt;
    logic            timeout;

    int total = 0;
    int bad   = 0;
    int tag_n = 0;

    typedef struct {
        logic [3:0]      grant;
        logic [CntW-1:0] cnt;
        logic            tmo;
        int              tag;
    } exp_t;

    exp_t sb[$];

    rr_burst_arbiter #(
        .MAX_BURST(MaxBurst),
        .CNT_W    (CntW),
        .TIMEOUT  (Timeout)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .last_i     (last),
        .ready_i    (ready),
        .grant_o    (grant),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id),
        .beat_cnt_o (beat_cnt),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, tag, act, want);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_grant"}, tag_n, 32'(grant), 32'd0);
        chk({name, "_valid"}, tag_n, 32'(gnt_valid), 32'd0);
        chk({name, "_id"}, tag_n, 32'(gnt_id), 32'd0);
        chk({name, "_cnt"}, tag_n, 32'(beat_cnt), 32'd0);
        chk({name, "_tmo"}, tag_n, 32'(timeout), 32'd0);
    endtask

    task automatic push(input logic [3:0] eg, input int ec, input logic et);
        exp_t e;
        tag_n++;
        e.grant = eg;
        e.cnt   = CntW'(ec);
        e.tmo   = et;
        e.tag   = tag_n;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input logic [3:0] eg, input int ec, input logic et);
        @(negedge clk);
        req   = r;
        last  = l;
        ready = rd;
        push(eg, ec, et);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("grant", e.tag, 32'(grant), 32'(e.grant));
                chk("gnt_valid", e.tag, 32'(gnt_valid), 32'(|e.grant));
                chk("gnt_id", e.tag, 32'(gnt_id), 32'(enc(e.grant)));
                chk("beat_cnt", e.tag, 32'(beat_cnt), 32'(e.cnt));
                chk("timeout", e.tag, 32'(timeout), 32'(e.tmo));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        #2 rst_n = 1'b0;
        #2 chk_idle("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation: every beat is a last beat, grants walk 0..3 with an idle gap.
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b1111, 1'b1, 4'(1 << i), 0, 1'b0);
            step(4'b1111, 4'b1111, 1'b1, 4'b0000, 0, 1'b0);
        end
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, 0, 1'b0);

        // Burst lock on requester 0 for 5 beats while requester 1 waits.
        for (int k = 1; k <= 4; k++) step(4'b0011, 4'b0000, 1'b1, 4'b0001, k, 1'b0);
        step(4'b0011, 4'b0001, 1'b1, 4'b0000, 0, 1'b0);
        step(4'b0011, 4'b0000, 1'b1, 4'b0010, 0, 1'b0);
        step(4'b0011, 4'b0001, 1'b1, 4'b0010, 1, 1'b0);
        step(4'b0011, 4'b0010, 1'b0, 4'b0010, 1, 1'b0);
        step(4'b0011, 4'b0010, 1'b1, 4'b0000, 0, 1'b0);

        // Burst limit: 8 beats without last, then ptr must land on 3.
        step(4'b0100, 4'b0000, 1'b1, 4'b0100, 0, 1'b0);
        for (int k = 1; k <= 7; k++) step(4'b0100, 4'b0000, 1'b1, 4'b0100, k, 1'b0);
        step(4'b0100, 4'b0000, 1'b1, 4'b0000, 0, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 4'b1000, 0, 1'b0);

        // Stall then abort of requester 3; search restarts at 0.
        step(4'b1111, 4'b0000, 1'b1, 4'b1000, 1, 1'b0);
        repeat (3) step(4'b1111, 4'b0000, 1'b0, 4'b1000, 1, 1'b0);
        step(4'b0111, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);
        step(4'b0111, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);
        step(4'b0110, 4'b0000, 1'b1, 4'b0000, 0, 1'b0);

        // Asynchronous reset during beat 3 of requester 1.
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, 0, 1'b0);
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, 1, 1'b0);
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, 2, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_idle("midreset");
        req   = 4'b1111;
        last  = 4'b0000;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(4'b0001, 0, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);

`ifdef RR_TIMEOUT_EN
        // Stall: 16 granted cycles with ready low, then forced release.
        repeat (14) step(4'b0011, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 4'b0000, 0, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 4'b0010, 0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);
`else
        // Without the stall limit the grant holds while ready stays low.
        repeat (20) step(4'b0011, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);
        step(4'b0011, 4'b0001, 1'b1, 4'b0000, 0, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 4'b0010, 0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);
`endif
        step(4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);

        @(posedge clk);
        #3;
        chk("sb_drained", tag_n, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- 4-requester round-robin arbiter with burst locking, placed in front of a single shared beat-oriented resource (bus or port).
- Arbitrates among requesters and holds the grant for a whole burst. The burst ends on `last`, at the MAX_BURST beat limit, or on requester abort. Fairness then rotates to the requester after the winner.
- Sequential companion to the combinational-rotate arbiter: registered grant, per-burst beat counter, two-state FSM.

Parameters:
- MAX_BURST, 8, maximum beats per grant before forced release; legal range 1..256.
- CNT_W, 8, beat-counter width; must satisfy 2^CNT_W >= MAX_BURST.
- TIMEOUT, 16, stall-cycle limit, used only with RR_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request lines; req[i] must stay high for the whole burst.
- last  input  4  last[i] marks the final beat of requester i's burst; sampled only on a beat.
- ready  input  1  downstream accepts a beat this cycle.
- grant  output  4  registered one-hot grant; 4'b0000 when idle.
- gnt_valid  output  1  high when grant is non-zero.
- gnt_id  output  2  encoded index of the granted requester; 0 when idle.
- beat_cnt  output  CNT_W  beats transferred in the current burst.
- timeout  output  1  one-cycle pulse on forced timeout release; tied 0 without the macro.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - grant=0, gnt_valid=0, gnt_id=0, beat_cnt=0, timeout=0.
  - ptr=0, FSM=IDLE.
  - Abandoned bursts are not resumed.
- Beat definition: beat = (state==GRANT) && req[gnt_id] && ready.
- IDLE state:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register grant for that bit, set gnt_id, go to GRANT.
  - Latency: req asserted in cycle N -> grant visible in cycle N+1.
  - If req==0, stay in IDLE and leave ptr unchanged.
- GRANT state, evaluated in priority order each cycle:
  1. Abort: req[gnt_id]==0 -> release.
  2. Beat with last[gnt_id]==1 -> release.
  3. Beat with beat_cnt==MAX_BURST-1 -> release (forced burst limit).
  4. Beat otherwise -> beat_cnt+1, stay in GRANT.
  5. No beat -> hold all state.
- Release:
  - Next cycle: grant=0, gnt_valid=0, gnt_id=0, beat_cnt=0.
  - ptr = released id + 1 (wrap 3->0); FSM=IDLE.
  - Exactly one idle cycle separates consecutive bursts.
- last and ready are don't-care outside a beat; last on non-granted lines is ignored.
- Requests from other requesters while in GRANT do not affect state; they are serviced in later IDLE arbitrations.
- MAX_BURST=1: every beat releases.
- beat_cnt never exceeds MAX_BURST-1 and never wraps.
- Invariants: grant is always zero or one-hot; gnt_valid == |grant.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - A stall counter clears on entering GRANT and on every beat.
  - It increments on each GRANT cycle with req[gnt_id]==1 and ready==0.
  - When it reaches TIMEOUT-1 and ready is still 0, force a release with the same ptr update as a normal release.
  - timeout=1 for the single cycle in which grant drops.
  - Abort takes priority over timeout; a beat in the same cycle suppresses timeout.
- Not defined: no stall counter; timeout held at 0; a grant may hold indefinitely while ready=0.

Test Plan:
- Rotation: req=4'b1111, ready=1, last=4'b1111 every beat -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; beat_cnt stays 0.
- Burst lock: req=4'b0011, requester 0 gets 5 beats with last on beat 5 -> grant=0001 for 5 beat cycles while req[1] stays high; beat_cnt reads 0..4; then one idle cycle; then grant=0010.
- Burst limit: MAX_BURST=8, req[2] held, ready=1, last=0 -> release after the 8th beat; grant=0100 for exactly 8 cycles; ptr=3.
- Abort and stall: grant=1000, ready=0 for 3 cycles (grant holds, beat_cnt unchanged), then req[3] drops -> grant=0000 next cycle; next winner is searched from index 0.
- Reset mid-burst: rst_n pulled low asynchronously at beat 3 of requester 1 -> grant=0, beat_cnt=0 immediately; after release with req=4'b1111, first grant is 0001.
- Timeout (RR_TIMEOUT_EN, TIMEOUT=16): grant=0001, ready=0 for 16 cycles -> grant=0000 and timeout=1 on the 17th cycle; next grant=0010 if req[1] is high.
